// File: rtl/cacheline_line_buffer.sv
// cacheline_line_buffer: holds one cacheline and moves it to/from the
// memory burst port as BEAT_WIDTH beats, optionally critical-beat-first.
package cache_types;
    typedef enum logic [2:0] {
        LINE_IDLE,
        WAIT,
        SERIALIZE,
        DESERIALIZE,
        DESERIALIZE_DONE
    } line_buffer_state_t;
endpackage

module cacheline_line_buffer
    import cache_types::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int WRAP_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_req_valid,
    output logic                  line_req_ready,
    input  logic                  line_req_write,
    input  logic [ADDR_WIDTH-1:0] line_req_addr,
    input  logic [LINE_WIDTH-1:0] line_req_wdata,
    output logic                  line_resp_valid,
    input  logic                  line_resp_ready,
    output logic [LINE_WIDTH-1:0] line_resp_rdata,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic                  mem_cmd_write,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    output logic                  mem_wdata_last,
    input  logic                  mem_rdata_valid,
    input  logic [BEAT_WIDTH-1:0] mem_rdata,
    output logic                  protocol_err
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam int BB    = $clog2(BEAT_WIDTH / 8);
    localparam int LB    = $clog2(LINE_WIDTH / 8);
    localparam int OFS   = (WRAP_EN != 0) ? BB : LB;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFS;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    line_buffer_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         start;
    logic [CW-1:0]         idx;
    logic                  req_fire;
    logic                  wbeat_fire;
    logic                  rbeat_fire;

    // Beat offset inside the line wraps naturally in CW bits.
    assign start = (WRAP_EN != 0) ? addr_q[LB-1:BB] : '0;
    assign idx   = start + cnt_q;

    assign req_fire   = (state_q == LINE_IDLE) && line_req_valid;
    assign wbeat_fire = (state_q == SERIALIZE) && mem_wdata_ready;
    assign rbeat_fire = (state_q == DESERIALIZE) && mem_rdata_valid;

    assign mem_cmd_write   = write_q;
    assign mem_cmd_addr    = addr_q & ADDR_MASK;
    assign line_resp_rdata = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LINE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        line_req_ready  = 1'b0;
        mem_cmd_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        mem_wdata_last  = 1'b0;
        line_resp_valid = 1'b0;
        unique case (state_q)
            LINE_IDLE: begin
                line_req_ready = 1'b1;
                if (line_req_valid) state_d = WAIT;
            end
            WAIT: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    state_d = write_q ? SERIALIZE : DESERIALIZE;
                end
            end
            SERIALIZE: begin
                mem_wdata_valid = 1'b1;
                mem_wdata_last  = (cnt_q == LAST);
                if (mem_wdata_ready && cnt_q == LAST) begin
                    state_d = DESERIALIZE_DONE;
                end
            end
            DESERIALIZE: begin
                if (mem_rdata_valid && cnt_q == LAST) begin
                    state_d = DESERIALIZE_DONE;
                end
            end
            DESERIALIZE_DONE: begin
                line_resp_valid = 1'b1;
                if (line_resp_ready) state_d = LINE_IDLE;
            end
            default: state_d = LINE_IDLE;
        endcase
        // Nothing handshakes while reset is held.
        if (rst) begin
            line_req_ready  = 1'b0;
            mem_cmd_valid   = 1'b0;
            mem_wdata_valid = 1'b0;
            mem_wdata_last  = 1'b0;
            line_resp_valid = 1'b0;
        end
    end

    always_comb begin
        protocol_err = mem_rdata_valid && !rst && (state_q != DESERIALIZE);
        mem_wdata    = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == CW'(k)) begin
                mem_wdata = line_q[k*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // Fills only touch line_q beat by beat, so a prior fill stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (req_fire) begin
                addr_q  <= line_req_addr;
                write_q <= line_req_write;
                cnt_q   <= '0;
                if (line_req_write) line_q <= line_req_wdata;
            end
            if (wbeat_fire) cnt_q <= cnt_q + CW'(1);
            if (rbeat_fire) begin
                cnt_q <= cnt_q + CW'(1);
                for (int k = 0; k < BEATS; k++) begin
                    if (idx == CW'(k)) begin
                        line_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cacheline_line_buffer.sv
// Bench for cacheline_line_buffer: wrap and linear instances side by side,
// scoreboard queues hold expected beats and lines.
module tb_cacheline_line_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         line_req_valid = 1'b0;
    logic         line_req_write = 1'b0;
    logic [31:0]  line_req_addr = '0;
    logic [255:0] line_req_wdata = '0;
    logic         line_resp_ready = 1'b0;
    logic         mem_cmd_ready = 1'b0;
    logic         mem_wdata_ready = 1'b0;
    logic         mem_rdata_valid = 1'b0;
    logic [63:0]  mem_rdata = '0;

    logic         line_req_ready, line_resp_valid, mem_cmd_valid;
    logic         mem_cmd_write, mem_wdata_valid, mem_wdata_last;
    logic         protocol_err;
    logic [255:0] line_resp_rdata;
    logic [31:0]  mem_cmd_addr;
    logic [63:0]  mem_wdata;

    logic         nw_line_req_ready, nw_line_resp_valid, nw_mem_cmd_valid;
    logic         nw_mem_cmd_write, nw_mem_wdata_valid, nw_mem_wdata_last;
    logic         nw_protocol_err;
    logic [255:0] nw_line_resp_rdata;
    logic [31:0]  nw_mem_cmd_addr;
    logic [63:0]  nw_mem_wdata;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0]  wq[$];
    logic [255:0] lq[$];
    logic [255:0] nq[$];
    logic [255:0] last_fill;

    always #5 clk = ~clk;

    cacheline_line_buffer dut (
        .clk(clk), .rst(rst),
        .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
        .line_req_write(line_req_write), .line_req_addr(line_req_addr),
        .line_req_wdata(line_req_wdata),
        .line_resp_valid(line_resp_valid), .line_resp_ready(line_resp_ready),
        .line_resp_rdata(line_resp_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(mem_cmd_write), .mem_cmd_addr(mem_cmd_addr),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_wdata_last(mem_wdata_last),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .protocol_err(protocol_err)
    );

    cacheline_line_buffer #(.WRAP_EN(0)) dut_nw (
        .clk(clk), .rst(rst),
        .line_req_valid(line_req_valid), .line_req_ready(nw_line_req_ready),
        .line_req_write(line_req_write), .line_req_addr(line_req_addr),
        .line_req_wdata(line_req_wdata),
        .line_resp_valid(nw_line_resp_valid), .line_resp_ready(line_resp_ready),
        .line_resp_rdata(nw_line_resp_rdata),
        .mem_cmd_valid(nw_mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_write(nw_mem_cmd_write), .mem_cmd_addr(nw_mem_cmd_addr),
        .mem_wdata_valid(nw_mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(nw_mem_wdata), .mem_wdata_last(nw_mem_wdata_last),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .protocol_err(nw_protocol_err)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [63:0] bt(input logic [31:0] tag, input int k);
        return {tag, 32'(k)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        line_req_valid = 1'b1;
        mem_rdata_valid = 1'b1;
        cyc(); #1;
        n_cmp++;
        if (line_req_ready !== 1'b0 || protocol_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cycle: ready=%b err=%b want 0 0",
                     line_req_ready, protocol_err);
        end
        n_cmp++;
        if (mem_cmd_valid !== 1'b0 || line_resp_valid !== 1'b0 ||
            mem_wdata_valid !== 1'b0 || mem_wdata_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valids: cmd=%b resp=%b wd=%b last=%b want 0",
                     mem_cmd_valid, line_resp_valid, mem_wdata_valid, mem_wdata_last);
        end
        cyc();
        rst = 1'b0;
        line_req_valid = 1'b0;
        mem_rdata_valid = 1'b0;
        #1;
        n_cmp++;
        if (line_req_ready !== 1'b1 || line_resp_rdata !== 256'h0) begin
            n_err++;
            $display("FAIL reset_idle: ready=%b rdata=%h want 1 0",
                     line_req_ready, line_resp_rdata);
        end
    endtask

    task automatic test_fill_wrap();
        logic [255:0] ew, en, e;
        logic [63:0] d;
        ew = '0;
        en = '0;
        cyc();
        line_req_valid = 1'b1;
        line_req_write = 1'b0;
        line_req_addr = 32'h1000_0010;
        mem_cmd_ready = 1'b1;
        #1;
        n_cmp++;
        if (line_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fill_req_ready: got %b want 1", line_req_ready);
        end
        cyc();
        line_req_valid = 1'b0;
        #1;
        n_cmp++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_write !== 1'b0 ||
            mem_cmd_addr !== 32'h1000_0010) begin
            n_err++;
            $display("FAIL fill_cmd: v=%b w=%b addr=%h want 1 0 10000010",
                     mem_cmd_valid, mem_cmd_write, mem_cmd_addr);
        end
        n_cmp++;
        if (nw_mem_cmd_addr !== 32'h1000_0000) begin
            n_err++;
            $display("FAIL nowrap_cmd_addr: got %h want 10000000", nw_mem_cmd_addr);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_cmd_ready = 1'b0;
            mem_rdata_valid = 1'b1;
            d = bt(32'hD0D0_D0D0, i);
            mem_rdata = d;
            ew[((i + 2) % 4)*64 +: 64] = d;
            en[i*64 +: 64] = d;
            #1;
            n_cmp++;
            if (line_resp_valid !== 1'b0 || mem_cmd_valid !== 1'b0) begin
                n_err++;
                $display("FAIL fill_beat%0d: resp=%b cmd=%b want 0 0",
                         i, line_resp_valid, mem_cmd_valid);
            end
        end
        lq.push_back(ew);
        nq.push_back(en);
        cyc();
        mem_rdata_valid = 1'b0;
        line_resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (line_resp_valid !== 1'b1 || nw_line_resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_resp_cycle6: wrap=%b nowrap=%b want 1 1",
                     line_resp_valid, nw_line_resp_valid);
        end
        e = lq.pop_front();
        n_cmp++;
        if (line_resp_rdata !== e) begin
            n_err++;
            $display("FAIL fill_wrap_line: got %h want %h", line_resp_rdata, e);
        end
        e = nq.pop_front();
        n_cmp++;
        if (nw_line_resp_rdata !== e) begin
            n_err++;
            $display("FAIL fill_nowrap_line: got %h want %h", nw_line_resp_rdata, e);
        end
        last_fill = ew;
        cyc();
        line_resp_ready = 1'b0;
        #1;
        n_cmp++;
        if (line_req_ready !== 1'b1 || line_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fill_back_idle: ready=%b resp=%b want 1 0",
                     line_req_ready, line_resp_valid);
        end
    endtask

    task automatic test_stray_idle();
        cyc();
        mem_rdata_valid = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        n_cmp++;
        if (protocol_err !== 1'b1) begin
            n_err++;
            $display("FAIL stray_idle_err: got %b want 1", protocol_err);
        end
        cyc();
        mem_rdata_valid = 1'b0;
        #1;
        n_cmp++;
        if (protocol_err !== 1'b0 || line_resp_rdata !== last_fill) begin
            n_err++;
            $display("FAIL stray_idle_after: err=%b line=%h want 0 %h",
                     protocol_err, line_resp_rdata, last_fill);
        end
    endtask

    task automatic test_writeback_stall();
        logic [63:0] e, held;
        logic rdy, held_v;
        int got;
        for (int k = 0; k < 4; k++) line_req_wdata[k*64 +: 64] = bt(32'hB0B0_B0B0, k);
        wq.push_back(bt(32'hB0B0_B0B0, 1));
        wq.push_back(bt(32'hB0B0_B0B0, 2));
        wq.push_back(bt(32'hB0B0_B0B0, 3));
        wq.push_back(bt(32'hB0B0_B0B0, 0));
        cyc();
        line_req_valid = 1'b1;
        line_req_write = 1'b1;
        line_req_addr = 32'h2000_0008;
        mem_cmd_ready = 1'b1;
        mem_wdata_ready = 1'b0;
        cyc();
        line_req_valid = 1'b0;
        #1;
        n_cmp++;
        if (mem_cmd_addr !== 32'h2000_0008 || mem_cmd_write !== 1'b1) begin
            n_err++;
            $display("FAIL wb_cmd: addr=%h w=%b want 20000008 1",
                     mem_cmd_addr, mem_cmd_write);
        end
        rdy = 1'b1;
        held_v = 1'b0;
        held = '0;
        got = 0;
        for (int t = 0; t < 40 && got < 4; t++) begin
            cyc();
            mem_cmd_ready = 1'b0;
            mem_wdata_ready = rdy;
            #1;
            n_cmp++;
            if (mem_wdata_valid !== 1'b1) begin
                n_err++;
                $display("FAIL wb_valid_t%0d: got %b want 1", t, mem_wdata_valid);
            end
            if (held_v) begin
                n_cmp++;
                if (mem_wdata !== held) begin
                    n_err++;
                    $display("FAIL wb_stable: got %h want %h", mem_wdata, held);
                end
            end
            n_cmp++;
            if (mem_wdata_last !== (got == 3)) begin
                n_err++;
                $display("FAIL wb_last_beat%0d: got %b want %b",
                         got, mem_wdata_last, (got == 3));
            end
            if (rdy) begin
                e = wq.pop_front();
                n_cmp++;
                if (mem_wdata !== e) begin
                    n_err++;
                    $display("FAIL wb_beat%0d: got %h want %h", got, mem_wdata, e);
                end
                got++;
                held_v = 1'b0;
            end else begin
                held = mem_wdata;
                held_v = 1'b1;
            end
            rdy = ~rdy;
        end
        if (got < 4) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_timeout: got %0d beats want 4", got);
        end
        cyc();
        mem_wdata_ready = 1'b0;
        line_resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (line_resp_valid !== 1'b1 || mem_wdata_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wb_resp: resp=%b wd=%b want 1 0",
                     line_resp_valid, mem_wdata_valid);
        end
        cyc();
        line_resp_ready = 1'b0;
    endtask

    task automatic test_cmd_stall_stray();
        logic [63:0] e;
        int got;
        for (int k = 0; k < 4; k++) begin
            line_req_wdata[k*64 +: 64] = bt(32'hC0C0_C0C0, k);
            wq.push_back(bt(32'hC0C0_C0C0, k));
        end
        cyc();
        line_req_valid = 1'b1;
        line_req_write = 1'b1;
        line_req_addr = 32'h3000_0000;
        mem_cmd_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            cyc();
            line_req_valid = 1'b0;
            #1;
            n_cmp++;
            if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h3000_0000 ||
                mem_wdata_valid !== 1'b0) begin
                n_err++;
                $display("FAIL cmd_stall_t%0d: v=%b addr=%h wd=%b want 1 30000000 0",
                         t, mem_cmd_valid, mem_cmd_addr, mem_wdata_valid);
            end
        end
        cyc();
        mem_cmd_ready = 1'b1;
        cyc();
        mem_cmd_ready = 1'b0;
        mem_rdata_valid = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        n_cmp++;
        if (protocol_err !== 1'b1 || mem_wdata_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stray_ser: err=%b wd=%b want 1 1",
                     protocol_err, mem_wdata_valid);
        end
        got = 0;
        for (int t = 0; t < 10 && got < 4; t++) begin
            cyc();
            mem_rdata_valid = 1'b0;
            mem_wdata_ready = 1'b1;
            #1;
            if (t == 0) begin
                n_cmp++;
                if (protocol_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL stray_ser_pulse: got %b want 0", protocol_err);
                end
            end
            if (mem_wdata_valid === 1'b1) begin
                e = wq.pop_front();
                n_cmp++;
                if (mem_wdata !== e || mem_wdata_last !== (got == 3)) begin
                    n_err++;
                    $display("FAIL stall_beat%0d: got %h/%b want %h/%b",
                             got, mem_wdata, mem_wdata_last, e, (got == 3));
                end
                got++;
            end
        end
        if (got < 4) begin
            n_cmp++;
            n_err++;
            $display("FAIL stall_timeout: got %0d beats want 4", got);
        end
        cyc();
        mem_wdata_ready = 1'b0;
        line_resp_ready = 1'b1;
        #1;
        n_cmp++;
        if (line_resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_resp: got %b want 1", line_resp_valid);
        end
        cyc();
        line_resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        logic [255:0] ex, e;
        logic [63:0] d;
        bit seen;
        cyc();
        line_req_valid = 1'b1;
        line_req_write = 1'b0;
        line_req_addr = 32'h1000_0000;
        mem_cmd_ready = 1'b1;
        cyc();
        line_req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            mem_cmd_ready = 1'b0;
            mem_rdata_valid = 1'b1;
            mem_rdata = bt(32'hEEEE_EEEE, i);
        end
        cyc();
        mem_rdata_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (line_req_ready !== 1'b0 || line_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_cycle: ready=%b resp=%b want 0 0",
                     line_req_ready, line_resp_valid);
        end
        cyc();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (line_req_ready !== 1'b1 || line_resp_valid !== 1'b0 ||
            line_resp_rdata !== 256'h0) begin
            n_err++;
            $display("FAIL rst_mid_after: ready=%b resp=%b line=%h want 1 0 0",
                     line_req_ready, line_resp_valid, line_resp_rdata);
        end
        ex = '0;
        line_req_valid = 1'b1;
        line_req_addr = 32'h1000_0018;
        mem_cmd_ready = 1'b1;
        cyc();
        line_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_cmd_ready = 1'b0;
            mem_rdata_valid = 1'b1;
            d = bt(32'hF0F0_F0F0, i);
            mem_rdata = d;
            ex[((i + 3) % 4)*64 +: 64] = d;
            #1;
            n_cmp++;
            if (line_resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL gap_beat%0d_resp: got %b want 0", i, line_resp_valid);
            end
            cyc();
            mem_rdata_valid = 1'b0;
        end
        lq.push_back(ex);
        line_resp_ready = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            #1;
            if (line_resp_valid === 1'b1) begin
                seen = 1'b1;
                e = lq.pop_front();
                n_cmp++;
                if (line_resp_rdata !== e) begin
                    n_err++;
                    $display("FAIL refill_line: got %h want %h", line_resp_rdata, e);
                end
            end
            cyc();
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL refill_timeout: resp=0 want 1");
        end
        line_resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [255:0] ex, e;
        cyc();
        line_req_valid = 1'b1;
        line_req_write = 1'b0;
        line_req_addr = 32'h0000_0000;
        mem_cmd_ready = 1'b1;
        cyc();
        line_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_cmd_ready = 1'b0;
            mem_rdata_valid = 1'b1;
            mem_rdata = bt(32'hA1A1_A1A1, i);
        end
        cyc();
        mem_rdata_valid = 1'b0;
        line_resp_ready = 1'b1;
        line_req_valid = 1'b1;
        line_req_addr = 32'h0000_0040;
        #1;
        n_cmp++;
        if (line_resp_valid !== 1'b1 || line_req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_resp_cycle: resp=%b ready=%b want 1 0",
                     line_resp_valid, line_req_ready);
        end
        cyc();
        line_resp_ready = 1'b0;
        mem_cmd_ready = 1'b1;
        #1;
        n_cmp++;
        if (line_req_ready !== 1'b1 || mem_cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle_gap: ready=%b cmd=%b want 1 0",
                     line_req_ready, mem_cmd_valid);
        end
        cyc();
        line_req_valid = 1'b0;
        #1;
        n_cmp++;
        if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h0000_0040) begin
            n_err++;
            $display("FAIL b2b_cmd: v=%b addr=%h want 1 00000040",
                     mem_cmd_valid, mem_cmd_addr);
        end
        ex = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_cmd_ready = 1'b0;
            mem_rdata_valid = 1'b1;
            mem_rdata = bt(32'hA2A2_A2A2, i);
            ex[i*64 +: 64] = mem_rdata;
        end
        lq.push_back(ex);
        cyc();
        mem_rdata_valid = 1'b0;
        line_resp_ready = 1'b1;
        #1;
        e = lq.pop_front();
        n_cmp++;
        if (line_resp_valid !== 1'b1 || line_resp_rdata !== e) begin
            n_err++;
            $display("FAIL b2b_line: v=%b got %h want %h",
                     line_resp_valid, line_resp_rdata, e);
        end
        cyc();
        line_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill_wrap();
        test_stray_idle();
        test_writeback_stall();
        test_cmd_stall_stray();
        test_reset_mid_fill();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
